// File: rtl/multicycle_ctrl_v2.sv
// Multicycle MIPS control FSM for a shared-memory datapath (PC, IR, MDR, regfile, ALU).
// It adds memory wait states, bne/jal/addi decoding and an illegal-opcode trap.
module multicycle_ctrl_v2 #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit EN_BNE      = 1'b1,
  parameter bit EN_JAL      = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondN,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ZeroExt,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR  = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC   = 4'd6,  S_RWB   = 4'd7,
    S_BEQ     = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC   = 4'd10, S_IWB   = 4'd11,
    S_BNE     = 4'd12, S_JAL    = 4'd13, S_ILLEGAL = 4'd14, S_SPARE = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  state_t state_q, state_d;
  logic   ready_s;

  // With wait states disabled the memory is treated as always ready.
  assign ready_s = MEM_WAIT_EN ? MemReady : 1'b1;

  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = ready_s ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW:                             state_d = S_MEMADR;
          OP_R:                                     state_d = S_REXEC;
          OP_BEQ:                                   state_d = S_BEQ;
          OP_J:                                     state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_IEXEC;
          OP_BNE:                                   state_d = EN_BNE ? S_BNE : S_ILLEGAL;
          OP_JAL:                                   state_d = EN_JAL ? S_JAL : S_ILLEGAL;
          default:                                  state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (Op == OP_SW)      state_d = S_MEMWR;
        else if (Op == OP_LW) state_d = S_MEMRD;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:  state_d = ready_s ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = ready_s ? S_FETCH : S_MEMWR;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore decode of the current state; everything is held low while in reset.
  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; PCWriteCondN = 1'b0; IorD = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; MemtoReg = 2'b00;
    RegDst = 2'b00; RegWrite = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 2'b00;
    ZeroExt = 1'b0; ALUOp = 3'b000; PCSource = 2'b00; IllegalOp = 1'b0;
    State = 4'd0;
    if (!Reset) begin
      State = 4'd0;
    end else begin
      State = state_q;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1; ALUSrcB = 2'b01;
          IRWrite = ready_s; PCWrite = ready_s;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        S_IEXEC: begin
          ALUSrcA = 1'b1; ALUSrcB = 2'b10;
          case (Op)
            OP_ANDI: begin ALUOp = 3'b011; ZeroExt = 1'b1; end
            OP_ORI:  begin ALUOp = 3'b100; ZeroExt = 1'b1; end
            OP_XORI: begin ALUOp = 3'b101; ZeroExt = 1'b1; end
            OP_LUI:  begin ALUOp = 3'b110; ZeroExt = 1'b1; end
            default: ALUOp = 3'b000;
          endcase
        end
        S_MEMRD:  begin IorD = 1'b1; MemRead = 1'b1; end
        S_MEMWR:  begin IorD = 1'b1; MemWrite = ready_s; end
        S_MEMWB:  begin RegWrite = 1'b1; MemtoReg = 2'b01; end
        S_REXEC:  begin ALUSrcA = 1'b1; ALUOp = 3'b010; end
        S_RWB:    begin RegWrite = 1'b1; RegDst = 2'b01; end
        S_IWB:    RegWrite = 1'b1;
        S_BEQ:    begin ALUSrcA = 1'b1; ALUOp = 3'b001; PCSource = 2'b01; PCWriteCond = 1'b1; end
        S_BNE:    begin ALUSrcA = 1'b1; ALUOp = 3'b001; PCSource = 2'b01; PCWriteCondN = 1'b1; end
        S_JUMP:   begin PCWrite = 1'b1; PCSource = 2'b10; end
        S_JAL: begin
          PCWrite = 1'b1; PCSource = 2'b10;
          RegWrite = 1'b1; RegDst = 2'b10; MemtoReg = 2'b10;
        end
        S_ILLEGAL: IllegalOp = 1'b1;
        default:   IllegalOp = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Directed bench for multicycle_ctrl_v2: one default instance and one with bne disabled,
// expected state/outputs per cycle pushed to a scoreboard queue and checked each cycle.
module tb_multicycle_ctrl_v2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [5:0]  Op;
  logic        MemReady;
  wire  [21:0] o1, o2;
  wire  [3:0]  st1, st2;

  always #5 Clk = ~Clk;

  multicycle_ctrl_v2 dut1 (
    .Clk(Clk), .Reset(Reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(o1[21]), .PCWriteCond(o1[20]), .PCWriteCondN(o1[19]), .IorD(o1[18]),
    .MemRead(o1[17]), .MemWrite(o1[16]), .IRWrite(o1[15]), .MemtoReg(o1[14:13]),
    .RegDst(o1[12:11]), .RegWrite(o1[10]), .ALUSrcA(o1[9]), .ALUSrcB(o1[8:7]),
    .ZeroExt(o1[6]), .ALUOp(o1[5:3]), .PCSource(o1[2:1]), .IllegalOp(o1[0]), .State(st1)
  );

  multicycle_ctrl_v2 #(.EN_BNE(1'b0)) dut2 (
    .Clk(Clk), .Reset(Reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(o2[21]), .PCWriteCond(o2[20]), .PCWriteCondN(o2[19]), .IorD(o2[18]),
    .MemRead(o2[17]), .MemWrite(o2[16]), .IRWrite(o2[15]), .MemtoReg(o2[14:13]),
    .RegDst(o2[12:11]), .RegWrite(o2[10]), .ALUSrcA(o2[9]), .ALUSrcB(o2[8:7]),
    .ZeroExt(o2[6]), .ALUOp(o2[5:3]), .PCSource(o2[2:1]), .IllegalOp(o2[0]), .State(st2)
  );

  localparam logic [21:0] PCW   = 22'd1 << 21;
  localparam logic [21:0] PCWC  = 22'd1 << 20;
  localparam logic [21:0] PCWCN = 22'd1 << 19;
  localparam logic [21:0] IORD  = 22'd1 << 18;
  localparam logic [21:0] MRD   = 22'd1 << 17;
  localparam logic [21:0] MWR   = 22'd1 << 16;
  localparam logic [21:0] IRW   = 22'd1 << 15;
  localparam logic [21:0] M2R_MDR = 22'd1 << 13;
  localparam logic [21:0] M2R_PC  = 22'd2 << 13;
  localparam logic [21:0] DST_RD  = 22'd1 << 11;
  localparam logic [21:0] DST_31  = 22'd2 << 11;
  localparam logic [21:0] RW    = 22'd1 << 10;
  localparam logic [21:0] SRCA  = 22'd1 << 9;
  localparam logic [21:0] SRCB_4   = 22'd1 << 7;
  localparam logic [21:0] SRCB_IMM = 22'd2 << 7;
  localparam logic [21:0] SRCB_BR  = 22'd3 << 7;
  localparam logic [21:0] ZEXT  = 22'd1 << 6;
  localparam logic [21:0] OP_SUB  = 22'd1 << 3;
  localparam logic [21:0] OP_RF   = 22'd2 << 3;
  localparam logic [21:0] OP_AND  = 22'd3 << 3;
  localparam logic [21:0] PCS_OUT = 22'd1 << 1;
  localparam logic [21:0] PCS_JMP = 22'd2 << 1;
  localparam logic [21:0] ILL   = 22'd1;

  localparam logic [21:0] E_FETCH  = PCW | MRD | IRW | SRCB_4;
  localparam logic [21:0] E_FWAIT  = MRD | SRCB_4;
  localparam logic [21:0] E_DECODE = SRCB_BR;
  localparam logic [21:0] E_MEMADR = SRCA | SRCB_IMM;

  typedef struct {
    logic [3:0]  s1;
    logic [21:0] v1;
    logic [3:0]  s2;
    logic [21:0] v2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step2(input logic [5:0] op, input logic rdy, input logic rst,
                       input logic [3:0] es1, input logic [21:0] eo1,
                       input logic [3:0] es2, input logic [21:0] eo2, input string tag);
    exp_t e;
    Op = op; MemReady = rdy; Reset = rst;
    sb.push_back('{es1, eo1, es2, eo2});
    #1;
    e = sb.pop_front();
    checks++;
    assert (st1 === e.s1) else begin
      errors++; $error("FAIL %s state: got %0d expected %0d", tag, st1, e.s1);
    end
    checks++;
    assert (o1 === e.v1) else begin
      errors++; $error("FAIL %s outputs: got %h expected %h", tag, o1, e.v1);
    end
    checks++;
    assert (st2 === e.s2) else begin
      errors++; $error("FAIL %s state(no-bne): got %0d expected %0d", tag, st2, e.s2);
    end
    checks++;
    assert (o2 === e.v2) else begin
      errors++; $error("FAIL %s outputs(no-bne): got %h expected %h", tag, o2, e.v2);
    end
    @(negedge Clk);
  endtask

  task automatic step(input logic [5:0] op, input logic rdy, input logic rst,
                      input logic [3:0] es, input logic [21:0] eo, input string tag);
    step2(op, rdy, rst, es, eo, es, eo, tag);
  endtask

  initial begin
    Reset = 1'b0; Op = 6'b000000; MemReady = 1'b1;
    @(negedge Clk);
    step(6'b000000, 1'b1, 1'b0, 4'd0, 22'd0, "reset0");
    step(6'b000000, 1'b1, 1'b0, 4'd0, 22'd0, "reset1");

    // lw, no waits
    step(6'b100011, 1'b1, 1'b1, 4'd0, E_FETCH,     "lw_fetch");
    step(6'b100011, 1'b1, 1'b1, 4'd1, E_DECODE,    "lw_decode");
    step(6'b100011, 1'b1, 1'b1, 4'd2, E_MEMADR,    "lw_memadr");
    step(6'b100011, 1'b1, 1'b1, 4'd3, IORD | MRD,  "lw_memrd");
    step(6'b100011, 1'b1, 1'b1, 4'd4, RW | M2R_MDR, "lw_memwb");

    // sw with MemReady low for three cycles in MEMWR
    step(6'b101011, 1'b1, 1'b1, 4'd0, E_FETCH,    "sw_fetch");
    step(6'b101011, 1'b1, 1'b1, 4'd1, E_DECODE,   "sw_decode");
    step(6'b101011, 1'b1, 1'b1, 4'd2, E_MEMADR,   "sw_memadr");
    step(6'b101011, 1'b0, 1'b1, 4'd5, IORD,       "sw_wait0");
    step(6'b101011, 1'b0, 1'b1, 4'd5, IORD,       "sw_wait1");
    step(6'b101011, 1'b0, 1'b1, 4'd5, IORD,       "sw_wait2");
    step(6'b101011, 1'b1, 1'b1, 4'd5, IORD | MWR, "sw_memwr");

    // R-type with one fetch wait cycle
    step(6'b000000, 1'b0, 1'b1, 4'd0, E_FWAIT,         "r_fwait");
    step(6'b000000, 1'b1, 1'b1, 4'd0, E_FETCH,         "r_fetch");
    step(6'b000000, 1'b1, 1'b1, 4'd1, E_DECODE,        "r_decode");
    step(6'b000000, 1'b1, 1'b1, 4'd6, SRCA | OP_RF,    "r_exec");
    step(6'b000000, 1'b1, 1'b1, 4'd7, RW | DST_RD,     "r_wb");

    // bne: decoded on dut1, trapped on dut2
    step(6'b000101, 1'b1, 1'b1, 4'd0, E_FETCH,  "bne_fetch");
    step(6'b000101, 1'b1, 1'b1, 4'd1, E_DECODE, "bne_decode");
    step2(6'b000101, 1'b1, 1'b1, 4'd12, PCWCN | SRCA | OP_SUB | PCS_OUT,
          4'd14, ILL, "bne_exec");

    // beq
    step(6'b000100, 1'b1, 1'b1, 4'd0, E_FETCH,  "beq_fetch");
    step(6'b000100, 1'b1, 1'b1, 4'd1, E_DECODE, "beq_decode");
    step(6'b000100, 1'b1, 1'b1, 4'd8, PCWC | SRCA | OP_SUB | PCS_OUT, "beq_exec");

    // jal
    step(6'b000011, 1'b1, 1'b1, 4'd0,  E_FETCH,  "jal_fetch");
    step(6'b000011, 1'b1, 1'b1, 4'd1,  E_DECODE, "jal_decode");
    step(6'b000011, 1'b1, 1'b1, 4'd13, PCW | PCS_JMP | RW | DST_31 | M2R_PC, "jal_exec");

    // andi then addi
    step(6'b001100, 1'b1, 1'b1, 4'd0,  E_FETCH,  "andi_fetch");
    step(6'b001100, 1'b1, 1'b1, 4'd1,  E_DECODE, "andi_decode");
    step(6'b001100, 1'b1, 1'b1, 4'd10, E_MEMADR | OP_AND | ZEXT, "andi_exec");
    step(6'b001100, 1'b1, 1'b1, 4'd11, RW, "andi_wb");
    step(6'b001000, 1'b1, 1'b1, 4'd0,  E_FETCH,  "addi_fetch");
    step(6'b001000, 1'b1, 1'b1, 4'd1,  E_DECODE, "addi_decode");
    step(6'b001000, 1'b1, 1'b1, 4'd10, E_MEMADR, "addi_exec");
    step(6'b001000, 1'b1, 1'b1, 4'd11, RW, "addi_wb");

    // unknown opcode traps on both
    step(6'b111111, 1'b1, 1'b1, 4'd0,  E_FETCH,  "ill_fetch");
    step(6'b111111, 1'b1, 1'b1, 4'd1,  E_DECODE, "ill_decode");
    step(6'b111111, 1'b1, 1'b1, 4'd14, ILL,      "ill_trap");

    // reset while waiting in MEMRD
    step(6'b100011, 1'b1, 1'b1, 4'd0, E_FETCH,    "rst_fetch");
    step(6'b100011, 1'b1, 1'b1, 4'd1, E_DECODE,   "rst_decode");
    step(6'b100011, 1'b1, 1'b1, 4'd2, E_MEMADR,   "rst_memadr");
    step(6'b100011, 1'b0, 1'b1, 4'd3, IORD | MRD, "rst_memrd_wait");
    step(6'b100011, 1'b0, 1'b0, 4'd0, 22'd0,     "rst_asserted");
    step(6'b100011, 1'b0, 1'b0, 4'd0, 22'd0,     "rst_held");
    step(6'b100011, 1'b0, 1'b1, 4'd0, E_FWAIT,    "rst_release");
    step(6'b100011, 1'b1, 1'b1, 4'd0, E_FETCH,    "rst_fetch2");
    step(6'b100011, 1'b1, 1'b1, 4'd1, E_DECODE,   "rst_decode2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
